// File: rtl/vga_scanout.sv
// VGA timing generator and frame-buffer scanout with a latency-matched control pipeline
// and a vblank-synchronised double-buffer swap.
module vga_scanout #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0,
   parameter int   MEM_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   output logic [10:0] rd_x,
   output logic [10:0] rd_y,
   output logic        rd_en,
   output logic        rd_buf,
   input  logic [3:0]  Red_in,
   input  logic [3:0]  Green_in,
   input  logic [3:0]  Blue_in,
   output logic [3:0]  Red,
   output logic [3:0]  Green,
   output logic [3:0]  Blue,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic        frame_start,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        fb_sel
);

   localparam int          H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int          V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
   localparam logic [10:0] V_LAST_VIS = 11'(V_ACTIVE - 1);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic {IDLE, PEND} swap_state_t;

   logic [10:0] hcnt_reg, vcnt_reg;
   logic [10:0] rd_x_reg, rd_y_reg;
   logic        rd_en_reg, hs_a_reg, vs_a_reg;
   logic [2:0]  ctl_pipe_reg [MEM_LAT];
   logic [3:0]  red_reg, green_reg, blue_reg;
   logic        active_reg, hsync_reg, vsync_reg, frame_start_reg;
   swap_state_t state_reg, state_next;
   logic        fb_sel_reg, fb_sel_next, swap_ack_reg, swap_ack_next;
   logic        h_wrap, v_wrap, vblank_tick, hs_now, vs_now, vis_now;
   logic [2:0]  ctl_d;

   assign h_wrap      = (hcnt_reg == H_LAST);
   assign v_wrap      = (vcnt_reg == V_LAST);
   assign vblank_tick = pix_en && h_wrap && (vcnt_reg == V_LAST_VIS);
   assign hs_now      = (hcnt_reg >= HS_START) && (hcnt_reg <= HS_END);
   assign vs_now      = (vcnt_reg >= VS_START) && (vcnt_reg <= VS_END);
   assign vis_now     = (hcnt_reg < H_VIS) && (vcnt_reg < V_VIS);

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_reg <= '0;
         vcnt_reg <= '0;
      end else if (pix_en) begin
         if (h_wrap) begin
            hcnt_reg <= '0;
            vcnt_reg <= v_wrap ? 11'd0 : vcnt_reg + 11'd1;
         end else begin
            hcnt_reg <= hcnt_reg + 11'd1;
         end
      end
   end

   // Address stage: sync/visibility flags are captured alongside the address they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_x_reg        <= '0;
         rd_y_reg        <= '0;
         rd_en_reg       <= 1'b0;
         hs_a_reg        <= 1'b0;
         vs_a_reg        <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= pix_en && (hcnt_reg == 11'd0) && (vcnt_reg == 11'd0);
         if (pix_en) begin
            rd_x_reg  <= hcnt_reg;
            rd_y_reg  <= vcnt_reg;
            rd_en_reg <= vis_now;
            hs_a_reg  <= hs_now;
            vs_a_reg  <= vs_now;
         end
      end
   end

   // Control flags ride a shift register as deep as the memory read latency.
   genvar gi;
   generate
      for (gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (rst)         ctl_pipe_reg[gi] <= '0;
               else if (pix_en) ctl_pipe_reg[gi] <= {rd_en_reg, hs_a_reg, vs_a_reg};
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (rst)         ctl_pipe_reg[gi] <= '0;
               else if (pix_en) ctl_pipe_reg[gi] <= ctl_pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign ctl_d = ctl_pipe_reg[MEM_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         red_reg    <= '0;
         green_reg  <= '0;
         blue_reg   <= '0;
         active_reg <= 1'b0;
         hsync_reg  <= ~SYNC_POL;
         vsync_reg  <= ~SYNC_POL;
      end else if (pix_en) begin
         active_reg <= ctl_d[2];
         red_reg    <= ctl_d[2] ? Red_in   : 4'd0;
         green_reg  <= ctl_d[2] ? Green_in : 4'd0;
         blue_reg   <= ctl_d[2] ? Blue_in  : 4'd0;
         hsync_reg  <= ctl_d[1] ? SYNC_POL : ~SYNC_POL;
         vsync_reg  <= ctl_d[0] ? SYNC_POL : ~SYNC_POL;
      end
   end

   // Swap is only granted on the tick that enters vblank, so the front buffer is stable all frame.
   always_comb begin
      state_next    = state_reg;
      fb_sel_next   = fb_sel_reg;
      swap_ack_next = 1'b0;
      case (state_reg)
         IDLE: if (swap_req) state_next = PEND;
         PEND: begin
            if (!swap_req) begin
               state_next = IDLE;
            end else if (vblank_tick) begin
               fb_sel_next   = ~fb_sel_reg;
               swap_ack_next = 1'b1;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         fb_sel_reg   <= 1'b0;
         swap_ack_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         fb_sel_reg   <= fb_sel_next;
         swap_ack_reg <= swap_ack_next;
      end
   end

   assign rd_x        = rd_x_reg;
   assign rd_y        = rd_y_reg;
   assign rd_en       = rd_en_reg;
   assign rd_buf      = fb_sel_reg;
   assign fb_sel      = fb_sel_reg;
   assign swap_ack    = swap_ack_reg;
   assign frame_start = frame_start_reg;
   assign Red         = red_reg;
   assign Green       = green_reg;
   assign Blue        = blue_reg;
   assign active      = active_reg;
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised-enable bench for vga_scanout on a shrunken raster, checked every clock against
// a tick-count reference model plus a behavioural frame-buffer memory.
module tb_vga_scanout;

   localparam int   HA = 16, HFP = 4, HSW = 6, HBP = 4;
   localparam int   HT = HA + HFP + HSW + HBP;
   localparam int   VA = 10, VFP = 2, VSW = 2, VBP = 3;
   localparam int   VT = VA + VFP + VSW + VBP;
   localparam int   FT = HT * VT;
   localparam int   LAT = 1;
   localparam logic POL = 1'b0;

   logic        clk = 1'b0;
   logic        rst, pix_en, swap_req;
   logic [10:0] rd_x, rd_y;
   logic        rd_en, rd_buf;
   logic [3:0]  Red_in, Green_in, Blue_in, Red, Green, Blue;
   logic        hsync, vsync, active, frame_start, swap_ack, fb_sel;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: ticks since reset, front buffer, request seen at previous edge
   int n_tick = 0;
   bit fb_m, seen_m, ack_m, fs_m;
   bit req_hold, alt;

   logic [11:0] mem_q [LAT];

   vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(POL), .MEM_LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rd_buf(rd_buf),
      .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
      .Red(Red), .Green(Green), .Blue(Blue),
      .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start),
      .swap_req(swap_req), .swap_ack(swap_ack), .fb_sel(fb_sel)
   );

   always #5 clk = ~clk;

   // frame-buffer memory: R=x[3:0], G=y[3:0], B=x[7:4], LAT enabled ticks of latency
   always @(posedge clk) begin
      if (pix_en) begin
         for (int i = LAT - 1; i > 0; i--) mem_q[i] <= mem_q[i-1];
         mem_q[0] <= {rd_x[3:0], rd_y[3:0], rd_x[7:4]};
      end
   end
   assign {Red_in, Green_in, Blue_in} = mem_q[LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (tick %0d, t=%0t)", tag, obs, exp, n_tick, $time);
      end
   endtask

   task automatic model_edge();
      int p;
      if (rst) begin
         n_tick = 0; fb_m = 0; seen_m = 0; ack_m = 0; fs_m = 0;
      end else begin
         ack_m = 0;
         fs_m  = 0;
         if (pix_en) begin
            p    = n_tick % FT;
            fs_m = (p == 0);
            if (p == VA * HT - 1 && seen_m && swap_req) begin
               fb_m  = ~fb_m;
               ack_m = 1;
            end
            n_tick++;
         end
         seen_m = swap_req;
      end
   endtask

   task automatic compare_all();
      int p, q;
      logic [10:0] x, y, qx, qy;
      logic        ren, act, hs_e, vs_e;
      logic [11:0] rgb;
      if (n_tick == 0) begin
         x = 0; y = 0; ren = 0;
      end else begin
         p   = (n_tick - 1) % FT;
         x   = 11'(p % HT);
         y   = 11'(p / HT);
         ren = (x < HA) && (y < VA);
      end
      q = n_tick - LAT - 2;
      if (q < 0) begin
         act = 0; hs_e = ~POL; vs_e = ~POL; rgb = '0;
      end else begin
         qx   = 11'((q % FT) % HT);
         qy   = 11'((q % FT) / HT);
         act  = (qx < HA) && (qy < VA);
         hs_e = (qx >= HA + HFP && qx < HA + HFP + HSW) ? POL : ~POL;
         vs_e = (qy >= VA + VFP && qy < VA + VFP + VSW) ? POL : ~POL;
         rgb  = act ? {qx[3:0], qy[3:0], qx[7:4]} : 12'd0;
      end
      check("rd_x", rd_x, x);
      check("rd_y", rd_y, y);
      check("rd_en", rd_en, ren);
      check("rd_buf", rd_buf, fb_m);
      check("fb_sel", fb_sel, fb_m);
      check("swap_ack", swap_ack, ack_m);
      check("frame_start", frame_start, fs_m);
      check("active", active, act);
      check("hsync", hsync, hs_e);
      check("vsync", vsync, vs_e);
      check("rgb", {Red, Green, Blue}, rgb);
   endtask

   // mode 0: pix_en always 1; mode 1: random 3/4 duty; mode 2: every other clock
   task automatic step(input bit r, input int mode);
      bit pe;
      case (mode)
         0: pe = 1'b1;
         1: pe = ($urandom_range(0, 3) != 0);
         default: begin alt = ~alt; pe = alt; end
      endcase
      rst = r; pix_en = pe; swap_req = req_hold;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (swap_ack) req_hold = 1'b0;
   endtask

   function automatic int cur_line();
      return (n_tick % FT) / HT;
   endfunction

   task automatic run(input int cycles, input int mode);
      for (int k = 0; k < cycles; k++) step(1'b0, mode);
   endtask

   task automatic run_to_line(input int line, input int mode);
      int k = 0;
      while (cur_line() != line && k < 4 * FT) begin
         step(1'b0, mode);
         k++;
      end
      if (cur_line() != line) check("line_wait", cur_line(), line);
   endtask

   task automatic phase_note(input string name);
      $display("phase %s: tick=%0d line=%0d fb_sel=%0b checks=%0d", name, n_tick, cur_line(), fb_sel, n_checks);
   endtask

   initial begin
      rst = 1'b1; pix_en = 1'b1; swap_req = 1'b0; req_hold = 1'b0; alt = 1'b0;
      @(negedge clk);
      repeat (3) step(1'b1, 0);
      phase_note("reset");

      // swap requested mid-visible: granted at the next vblank start
      run_to_line(3, 0);
      req_hold = 1'b1;
      run(2 * FT, 0);
      phase_note("swap_visible");

      // request withdrawn before vblank: no swap
      run_to_line(2, 1);
      req_hold = 1'b1;
      run_to_line(5, 1);
      req_hold = 1'b0;
      run(FT, 1);
      phase_note("swap_withdrawn");

      // pix_en every other clock
      run(2 * FT, 2);
      phase_note("half_rate");

      // reset mid-frame with a pending request: rst wins, fb_sel returns to 0
      run_to_line(3, 1);
      req_hold = 1'b1;
      run_to_line(6, 1);
      step(1'b1, 1);
      req_hold = 1'b0;
      step(1'b1, 1);
      run(FT / 2, 1);
      phase_note("mid_reset");

      // request first seen in vblank waits for the following vblank start
      run_to_line(VA + 2, 1);
      req_hold = 1'b1;
      run(3 * FT, 1);
      phase_note("swap_in_vblank");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
